// File: rtl/async_fifo_pkg.sv
// Shared types for the async_fifo read-side stream adapter.
// Buffer occupancy is encoded directly as the state so it can drive `level` unchanged.
// DSIZE_DEF is the default data width, matching the async_fifo default.
package async_fifo_pkg;

  localparam int DSIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the adapter.
// master: the adapter (pops the FIFO, drives the stream).
// slave: the FIFO model / consumer side.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);

  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  rdata, rempty, m_ready,
    output rinc, m_data, m_valid
  );

  modport slave (
    output rdata, rempty, m_ready,
    input  rinc, m_data, m_valid
  );

endinterface

// File: rtl/fifo_skid2.sv
// Two-entry head/skid buffer: head register drives the stream, skid holds the second word.
// Latency: a pushed word reaches the head one cycle later if the head is free or being popped.
// Backpressure: the caller must not push in ST_TWO; head/valid hold while valid & ~ready.
module fifo_skid2
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_dat_i,
  input  logic             ready_i,
  output logic [DSIZE-1:0] head_o,
  output logic             valid_o,
  output cnt_state_e       state_o
);

  cnt_state_e       state_q;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] skid_q;
  logic             valid_q;
  logic             pop;

  assign pop     = valid_q & ready_i;
  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

  // Occupancy FSM; head/skid move so that the oldest word is always in the head.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= ST_EMPTY;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_i) begin
            head_q  <= push_dat_i;
            valid_q <= 1'b1;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push_i && !pop) begin
            skid_q  <= push_dat_i;
            state_q <= ST_TWO;
          end else if (!push_i && pop) begin
            valid_q <= 1'b0;
            state_q <= ST_EMPTY;
          end else if (push_i && pop) begin
            // Head leaves this cycle, so the new word bypasses the skid.
            head_q <= push_dat_i;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for async_fifo: pops rdata into a 2-entry buffer, presents a registered stream.
// Latency: 1 cycle from rdata (rempty=0) to m_valid when the head is free; 1 word/cycle sustained.
// Backpressure: rinc uses only registered occupancy, never m_ready. Stats ports need FIFO_RD_STATS_EN.
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNTW  = 32
) (
  input  logic            rclk,
  input  logic            rrst,
  input  logic            flush,
  fifo_rd_stream_if.master bus,
  output logic [1:0]      level,
  output logic [CNTW-1:0] words_out,
  output logic [CNTW-1:0] stall_cyc
);

  cnt_state_e cnt;

  // Pop only when a slot is guaranteed free at the next edge, independent of m_ready.
  assign bus.rinc = ~bus.rempty & ~flush & ~rrst & (cnt != ST_TWO);
  assign level    = cnt;

  fifo_skid2 #(.DSIZE(DSIZE)) u_skid (
    .clk_i      (rclk),
    .rst_i      (rrst),
    .flush_i    (flush),
    .push_i     (bus.rinc),
    .push_dat_i (bus.rdata),
    .ready_i    (bus.m_ready),
    .head_o     (bus.m_data),
    .valid_o    (bus.m_valid),
    .state_o    (cnt)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNTW-1:0] words_q, words_d;
  logic [CNTW-1:0] stall_q, stall_d;

  // Saturating next-state for both counters; a transfer during flush still counts.
  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (bus.m_valid && bus.m_ready && (words_q != '1)) words_d = words_q + 1'b1;
    if (bus.m_valid && !bus.m_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign words_out = words_q;
  assign stall_cyc = stall_q;
`else
  assign words_out = '0;
  assign stall_cyc = '0;
`endif

endmodule
